bus_timer: RTL
==============

BUS_TIMER -- requirements
Module: bus_timer

Interface
REQ-001 W, 32, data/count width; only the value 32 is supported.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 addr  input  2  word select: 0=CTRL, 1=PRESET, 2=COUNT, 3=reserved.
REQ-005 we  input  1  write strobe, sampled on the rising clk edge.
REQ-006 wdata  input  W  write data.
REQ-007 rdata  output  W  read data; combinational from addr.
REQ-008 irq  output  1  interrupt request, registered.

Function
REQ-009 CTRL fields SHALL be: bit0 EN (enable), bits2:1 MODE (00 one-shot, 01 auto-reload, 1x treated as 00), bit3 IM (interrupt mask, 1 = irq enabled); bits 31:4 SHALL read 0.
REQ-010 PRESET SHALL be fully read/write.
REQ-011 COUNT SHALL be read-only; writes to addr 2 or addr 3 SHALL be ignored.
REQ-012 Reads of addr 3 SHALL return 0.
REQ-013 FSM states SHALL be IDLE, LOAD, CNT and INT.
REQ-014 IDLE: when EN=1 (after any same-edge write), next state SHALL be LOAD.
REQ-015 LOAD: COUNT<=PRESET; next state SHALL be CNT.
REQ-016 CNT: if EN=0, next state SHALL be IDLE with COUNT held.
REQ-017 CNT: else if COUNT==0, next state SHALL be INT.
REQ-018 CNT: else COUNT<=COUNT-1, with no wrap below 0.
REQ-019 INT: the done flag SHALL be set for one edge.
REQ-020 INT, MODE=00: EN SHALL be cleared and next state SHALL be IDLE.
REQ-021 INT, MODE=01: next state SHALL be LOAD.
REQ-022 Done flag: in MODE=00 it SHALL stay set until the next CTRL write; in MODE=01 it SHALL clear on the edge after INT.
REQ-023 irq SHALL equal done flag AND IM, registered; it SHALL change on the same edge the flag changes.
REQ-024 Latency: a CTRL write with EN=1 from IDLE SHALL assert irq (IM=1) after PRESET+3 rising edges, counted from the write edge.
REQ-025 MODE=01 irq period SHALL be PRESET+3 cycles, with irq high for 1 cycle per period.
REQ-026 PRESET=0: LOAD->CNT->INT; irq SHALL assert 3 edges after enable.
REQ-027 A PRESET write while in CNT SHALL NOT alter the running COUNT; it SHALL take effect at the next LOAD.
REQ-028 A CTRL write with EN=0 on the same edge COUNT reaches 0 in CNT SHALL win: next state IDLE, no INT, no irq.
REQ-029 A CTRL write in state INT SHALL update CTRL; the INT state's EN-clear (MODE=00) SHALL be overridden by the written EN value.
REQ-030 A CTRL write SHALL clear the done flag on that edge, except a write occurring in INT, where the flag SHALL still be set.

Reset
REQ-031 reset low SHALL immediately force: state IDLE, CTRL=0, PRESET=0, COUNT=0, done flag=0, irq=0.
REQ-032 Reset assertion mid-count SHALL abort the count with no irq.
REQ-033 Operation SHALL resume on the first clk edge after reset deasserts.

Structure
REQ-034 A shared package timer_pkg SHALL hold the state encoding (2-bit enum), register address constants, CTRL bit positions and MODE codes.
REQ-035 The block SHALL be a single module with no sub-module; the FSM, register file and read mux SHALL be in one file.

Verification
REQ-036 Reset during CNT with COUNT=5 -> all outputs and registers read 0 immediately; irq=0.
REQ-037 PRESET=3, CTRL=0x9 (EN, IM, one-shot) -> COUNT reads 3,2,1,0; irq rises on edge 6 after the write and stays high; CTRL reads 0x8; a write CTRL=0x8 drops irq.
REQ-038 PRESET=2, CTRL=0xB (auto-reload, IM) -> irq 1-cycle pulses every 5 cycles, 4 consecutive pulses checked.
REQ-039 PRESET=0, CTRL=0x9 -> irq asserts 3 edges after the write.
REQ-040 CTRL=0x1 (IM=0), PRESET=4 -> FSM reaches INT, irq stays 0; then a write CTRL=0x9 while in IDLE -> irq stays 0 because the flag was cleared.
REQ-041 Write CTRL=0x0 on the edge COUNT hits 0 -> no irq, state IDLE; a write PRESET=7 mid-count -> current COUNT sequence unchanged.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared definitions for the bus timer: FSM encoding, register map,
// CTRL field positions and MODE codes.
package timer_pkg;

  localparam int timer_w = 32;

  typedef enum logic [1:0] {
    st_idle = 2'd0,
    st_load = 2'd1,
    st_cnt  = 2'd2,
    st_int  = 2'd3
  } state_t;

  localparam logic [1:0] addr_ctrl   = 2'd0;
  localparam logic [1:0] addr_preset = 2'd1;
  localparam logic [1:0] addr_count  = 2'd2;

  localparam int ctrl_en_bit   = 0;
  localparam int ctrl_mode_lsb = 1;
  localparam int ctrl_mode_msb = 2;
  localparam int ctrl_im_bit   = 3;

  localparam logic [1:0] mode_oneshot = 2'b00;
  localparam logic [1:0] mode_auto    = 2'b01;

endpackage

// File: rtl/bus_timer.sv
// Bus-programmable down-counting timer with one-shot / auto-reload modes
// and a maskable registered interrupt.
//
// state   | meaning
// --------+------------------------------------------------------------
// st_idle | stopped; waits for EN (including an EN written on this edge)
// st_load | copies PRESET into COUNT
// st_cnt  | counts COUNT down to zero; EN=0 stops and holds COUNT
// st_int  | sets done; one-shot clears EN, auto-reload reloads
module bus_timer
  import timer_pkg::*;
#(
  parameter int W = timer_w
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [1:0]   addr,
  input  logic         we,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         irq
);

  state_t       state, state_nxt;
  logic         ctrl_en, ctrl_im;
  logic [1:0]   ctrl_mode;
  logic [W-1:0] preset, count, count_nxt;
  logic         done, done_nxt;
  logic         en_nxt;

  logic         ctrl_wr, preset_wr;
  logic         en_w, im_w;
  logic [1:0]   mode_w;
  logic         auto_mode;

  assign ctrl_wr   = we && (addr == addr_ctrl);
  assign preset_wr = we && (addr == addr_preset);

  // CTRL as it will be after this edge's write; the FSM acts on these.
  assign en_w   = ctrl_wr ? wdata[ctrl_en_bit] : ctrl_en;
  assign im_w   = ctrl_wr ? wdata[ctrl_im_bit] : ctrl_im;
  assign mode_w = ctrl_wr ? wdata[ctrl_mode_msb:ctrl_mode_lsb] : ctrl_mode;

  // Reserved MODE encodings behave as one-shot.
  assign auto_mode = (ctrl_mode == mode_auto);

  always_comb begin
    state_nxt = state;
    count_nxt = count;
    en_nxt    = en_w;
    case (state)
      st_idle: begin
        if (en_w) state_nxt = st_load;
      end
      st_load: begin
        count_nxt = preset;
        state_nxt = st_cnt;
      end
      st_cnt: begin
        if (!en_w) begin
          state_nxt = st_idle;
        end else if (count == '0) begin
          state_nxt = st_int;
        end else begin
          count_nxt = count - W'(1);
        end
      end
      st_int: begin
        if (auto_mode) begin
          state_nxt = st_load;
        end else begin
          state_nxt = st_idle;
          // A CTRL write landing in INT keeps the written EN.
          if (!ctrl_wr) en_nxt = 1'b0;
        end
      end
      default: state_nxt = st_idle;
    endcase
  end

  always_comb begin
    done_nxt = done;
    if (state == st_int) begin
      done_nxt = 1'b1;
    end else if (ctrl_wr || auto_mode) begin
      done_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= st_idle;
      ctrl_en   <= 1'b0;
      ctrl_mode <= mode_oneshot;
      ctrl_im   <= 1'b0;
      preset    <= '0;
      count     <= '0;
      done      <= 1'b0;
      irq       <= 1'b0;
    end else begin
      state     <= state_nxt;
      ctrl_en   <= en_nxt;
      ctrl_mode <= mode_w;
      ctrl_im   <= im_w;
      if (preset_wr) preset <= wdata;
      count     <= count_nxt;
      done      <= done_nxt;
      irq       <= done_nxt & im_w;
    end
  end

  always_comb begin
    rdata = '0;
    case (addr)
      addr_ctrl:   rdata = {{(W-4){1'b0}}, ctrl_im, ctrl_mode, ctrl_en};
      addr_preset: rdata = preset;
      addr_count:  rdata = count;
      default:     rdata = '0;
    endcase
  end

endmodule
